// File: rtl/addsub_pkg.sv
// Shared encodings for the digit-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_if.sv
// Request/result bundle between a requester and addsub_seq.
interface addsub_seq_if #(parameter int WIDTH = 8);
  logic             iStart;
  logic             iSA;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic [WIDTH:0]   oData;
  logic             oData_C;
  logic             oOverflow;
  logic             oBusy;
  logic             oDone;

  modport master (
    output iStart, iSA, iData_a, iData_b,
    input  oData, oData_C, oOverflow, oBusy, oDone
  );

  modport slave (
    input  iStart, iSA, iData_a, iData_b,
    output oData, oData_C, oOverflow, oBusy, oDone
  );
endinterface

// File: rtl/addsub_seq_digit_adder.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry entering
// the top bit so the parent can compute signed overflow.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] iA,
  input  logic [DIGIT-1:0] iB,
  input  logic             iCarry,
  output logic [DIGIT-1:0] oSum,
  output logic             oCarry,
  output logic             oCarryMsb
);

  logic c;

  // Ripple through the slice LSB first, capturing the carry into the MSB.
  always_comb begin
    c         = iCarry;
    oSum      = '0;
    oCarryMsb = iCarry;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) oCarryMsb = c;
      oSum[i] = iA[i] ^ iB[i] ^ c;
      c       = (iA[i] & iB[i]) | (c & (iA[i] ^ iB[i]));
    end
    oCarry = c;
  end

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial two's complement add/subtract: DIGIT bits per clock,
// WIDTH/DIGIT run cycles, one-cycle done pulse, back-to-back capable.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic         iClk,
  input  logic         iReset,
  addsub_seq_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0 || WIDTH < 4 || WIDTH > 32 || DIGIT < 1) begin : gBadParams
    $error("addsub_seq: WIDTH must be 4..32 and a multiple of DIGIT");
  end

  state_t           state, nextState;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             mode;
  logic [WIDTH-1:0] aReg, bReg, resReg, resNext;
  logic [WIDTH:0]   dataR;
  logic             dataCR, ovR;

  logic [DIGIT-1:0] sliceA, sliceB, sliceSum;
  logic             sliceCout, sliceCMsb;
  logic             lastDigit, accept;

  assign lastDigit = (state == RUN) && (cnt == CW'(N - 1));
  // New work is only taken when not mid-operation; starts in RUN are dropped.
  assign accept    = ((state == IDLE) || (state == DONE)) && bus.iStart;

  // Subtract is A + ~B + 1; the +1 comes from the carry preload on accept.
  assign sliceA  = aReg[DIGIT-1:0];
  assign sliceB  = (mode == SUB) ? ~bReg[DIGIT-1:0] : bReg[DIGIT-1:0];
  assign resNext = (resReg >> DIGIT) | (WIDTH'(sliceSum) << (WIDTH - DIGIT));

  digit_adder #(.DIGIT(DIGIT)) uSlice (
    .iA       (sliceA),
    .iB       (sliceB),
    .iCarry   (carry),
    .oSum     (sliceSum),
    .oCarry   (sliceCout),
    .oCarryMsb(sliceCMsb)
  );

  // State register.
  always_ff @(posedge iClk) begin
    if (iReset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; the spare code 2'd3 falls back to IDLE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.iStart) nextState = RUN;
      RUN:     if (lastDigit) nextState = DONE;
      DONE:    nextState = bus.iStart ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, per-digit shift/accumulate and result publication.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      cnt    <= '0;
      carry  <= 1'b0;
      mode   <= ADD;
      aReg   <= '0;
      bReg   <= '0;
      resReg <= '0;
      dataR  <= '0;
      dataCR <= 1'b0;
      ovR    <= 1'b0;
    end else if (accept) begin
      aReg  <= bus.iData_a;
      bReg  <= bus.iData_b;
      mode  <= bus.iSA;
      carry <= bus.iSA;
      cnt   <= '0;
    end else if (state == RUN) begin
      aReg   <= aReg >> DIGIT;
      bReg   <= bReg >> DIGIT;
      carry  <= sliceCout;
      resReg <= resNext;
      cnt    <= cnt + CW'(1);
      if (lastDigit) begin
        // Sign of the widened result: A, B' sign-extended plus the carry out.
        dataR  <= {sliceA[DIGIT-1] ^ sliceB[DIGIT-1] ^ sliceCout, resNext};
        dataCR <= sliceCout;
        ovR    <= sliceCMsb ^ sliceCout;
      end
    end
  end

  assign bus.oData     = dataR;
  assign bus.oData_C   = dataCR;
  assign bus.oOverflow = ovR;
  assign bus.oBusy     = (state == RUN);
  assign bus.oDone     = (state == DONE);

endmodule

// File: tb/tb_addsub_seq.sv
// Directed checks on the 8/2 configuration plus a model-based sweep on
// 16/4 and 16/1 configurations.
module tb_addsub_seq;
  import addsub_pkg::*;

  logic iClk = 1'b0;
  logic iReset;
  always #5 iClk = ~iClk;

  addsub_seq_if #(.WIDTH(8))  bus8 ();
  addsub_seq_if #(.WIDTH(16)) bus16a ();
  addsub_seq_if #(.WIDTH(16)) bus16b ();

  addsub_seq #(.WIDTH(8),  .DIGIT(2)) dut8   (.iClk(iClk), .iReset(iReset), .bus(bus8));
  addsub_seq #(.WIDTH(16), .DIGIT(4)) dut16a (.iClk(iClk), .iReset(iReset), .bus(bus16a));
  addsub_seq #(.WIDTH(16), .DIGIT(1)) dut16b (.iClk(iClk), .iReset(iReset), .bus(bus16b));

  int nChecks = 0;
  int nErrors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // One 8-bit operation with hand-computed expectations.
  task automatic op8(input string tag, input logic sa, input logic [7:0] a, input logic [7:0] b,
                     input logic [8:0] expD, input logic expC, input logic expV);
    int lat;
    bit seen;
    bus8.iSA = sa; bus8.iData_a = a; bus8.iData_b = b; bus8.iStart = 1'b1;
    tick();
    bus8.iStart = 1'b0;
    lat = 1;
    chk({tag, "/busy"}, 64'(bus8.oBusy), 64'd1);
    bus8.iData_a = ~a; bus8.iData_b = a ^ b ^ 8'h5A; bus8.iSA = ~sa;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      seen = bus8.oDone;
    end
    chk({tag, "/lat"}, 64'(lat), 64'd5);
    chk({tag, "/data"}, 64'(bus8.oData), 64'(expD));
    chk({tag, "/c"}, 64'(bus8.oData_C), 64'(expC));
    chk({tag, "/ovf"}, 64'(bus8.oOverflow), 64'(expV));
    tick();
    chk({tag, "/pulse"}, 64'(bus8.oDone), 64'd0);
    chk({tag, "/hold"}, 64'(bus8.oData), 64'(expD));
  endtask

  // Reference: exact signed arithmetic, carry from unsigned comparison.
  task automatic model(input int w, input bit sub, input longint a, input longint b,
                       output logic [63:0] d, output logic c, output logic v);
    longint lim, sa, sb, r;
    lim = longint'(1) <<< (w - 1);
    sa  = (a >= lim) ? a - 2 * lim : a;
    sb  = (b >= lim) ? b - 2 * lim : b;
    r   = sub ? sa - sb : sa + sb;
    v   = (r >= lim) || (r < -lim);
    d   = 64'(r & (4 * lim - 1));
    c   = sub ? (a >= b) : ((((a + b) >>> w) & 1) != 0);
  endtask

  initial begin
    int k, doneCnt, cyc, latA, latB;
    bit seen, seenA, seenB;
    logic [63:0] md;
    logic mc, mv;
    logic [15:0] ra, rb;
    logic rs;

    bus8.iStart = 0; bus8.iSA = 0; bus8.iData_a = 0; bus8.iData_b = 0;
    bus16a.iStart = 0; bus16a.iSA = 0; bus16a.iData_a = 0; bus16a.iData_b = 0;
    bus16b.iStart = 0; bus16b.iSA = 0; bus16b.iData_a = 0; bus16b.iData_b = 0;
    iReset = 1'b1;
    tick(); tick();
    chk("rst/data", 64'(bus8.oData), 64'd0);
    chk("rst/c", 64'(bus8.oData_C), 64'd0);
    chk("rst/ovf", 64'(bus8.oOverflow), 64'd0);
    chk("rst/busy", 64'(bus8.oBusy), 64'd0);
    chk("rst/done", 64'(bus8.oDone), 64'd0);
    chk("rst/busy16", 64'({bus16a.oBusy, bus16b.oBusy}), 64'd0);
    iReset = 1'b0;
    tick();

    op8("add04+06", ADD, 8'h04, 8'h06, 9'h00A, 1'b0, 1'b0);
    op8("add7F+FF", ADD, 8'h7F, 8'hFF, 9'h07E, 1'b1, 1'b0);
    op8("add7F+01", ADD, 8'h7F, 8'h01, 9'h080, 1'b0, 1'b1);
    op8("sub41-42", SUB, 8'h41, 8'h42, 9'h1FF, 1'b0, 1'b0);
    op8("sub80-01", SUB, 8'h80, 8'h01, 9'h17F, 1'b1, 1'b1);
    op8("sub00-80", SUB, 8'h00, 8'h80, 9'h080, 1'b0, 1'b1);
    op8("add80+80", ADD, 8'h80, 8'h80, 9'h100, 1'b1, 1'b1);

    // Reset during the second RUN cycle, with a start in the same cycle.
    bus8.iSA = ADD; bus8.iData_a = 8'h33; bus8.iData_b = 8'h11; bus8.iStart = 1'b1;
    tick();
    bus8.iStart = 1'b0;
    tick();
    iReset = 1'b1; bus8.iStart = 1'b1;
    tick();
    iReset = 1'b0; bus8.iStart = 1'b0;
    chk("midrst/data", 64'(bus8.oData), 64'd0);
    chk("midrst/c", 64'(bus8.oData_C), 64'd0);
    chk("midrst/ovf", 64'(bus8.oOverflow), 64'd0);
    chk("midrst/busy", 64'(bus8.oBusy), 64'd0);
    chk("midrst/done", 64'(bus8.oDone), 64'd0);
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.oDone) doneCnt++;
    end
    chk("midrst/nodone", 64'(doneCnt), 64'd0);
    op8("postrst", ADD, 8'h01, 8'h02, 9'h003, 1'b0, 1'b0);

    // Back-to-back: start held high through RUN and DONE.
    bus8.iSA = ADD; bus8.iData_a = 8'h10; bus8.iData_b = 8'h20; bus8.iStart = 1'b1;
    tick();
    bus8.iSA = SUB; bus8.iData_a = 8'h05; bus8.iData_b = 8'h09;
    k = 1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(); k++; seen = bus8.oDone;
    end
    chk("b2b/lat1", 64'(k), 64'd5);
    chk("b2b/data1", 64'(bus8.oData), 64'h030);
    k = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(); k++;
      if (k == 1) begin
        bus8.iStart = 1'b0; bus8.iData_a = 8'hEE; bus8.iData_b = 8'h77; bus8.iSA = ADD;
      end
      seen = bus8.oDone;
    end
    chk("b2b/lat2", 64'(k), 64'd5);
    chk("b2b/data2", 64'(bus8.oData), 64'h1FC);
    chk("b2b/c2", 64'(bus8.oData_C), 64'd0);
    tick();
    chk("b2b/idle", 64'({bus8.oBusy, bus8.oDone}), 64'd0);

    // Sweep on both 16-bit configurations with identical operands.
    for (int n = 0; n < 24; n++) begin
      case (n)
        0:       begin ra = 16'h7FFF; rb = 16'h0001; rs = ADD; end
        1:       begin ra = 16'h8000; rb = 16'h0001; rs = SUB; end
        2:       begin ra = 16'hFFFF; rb = 16'hFFFF; rs = ADD; end
        3:       begin ra = 16'h0000; rb = 16'h0000; rs = SUB; end
        default: begin ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1)); end
      endcase
      model(16, rs, longint'(ra), longint'(rb), md, mc, mv);
      bus16a.iData_a = ra; bus16a.iData_b = rb; bus16a.iSA = rs; bus16a.iStart = 1'b1;
      bus16b.iData_a = ra; bus16b.iData_b = rb; bus16b.iSA = rs; bus16b.iStart = 1'b1;
      tick();
      bus16a.iStart = 1'b0; bus16b.iStart = 1'b0;
      bus16a.iData_a = ~ra; bus16b.iData_b = ~rb;
      cyc = 1; latA = 0; latB = 0; seenA = 1'b0; seenB = 1'b0;
      for (int i = 0; i < 40 && !(seenA && seenB); i++) begin
        tick(); cyc++;
        if (!seenA && bus16a.oDone) begin
          seenA = 1'b1; latA = cyc;
          chk("d4/data", 64'(bus16a.oData), md);
          chk("d4/c", 64'(bus16a.oData_C), 64'(mc));
          chk("d4/ovf", 64'(bus16a.oOverflow), 64'(mv));
        end
        if (!seenB && bus16b.oDone) begin
          seenB = 1'b1; latB = cyc;
          chk("d1/data", 64'(bus16b.oData), md);
          chk("d1/c", 64'(bus16b.oData_C), 64'(mc));
          chk("d1/ovf", 64'(bus16b.oOverflow), 64'(mv));
        end
      end
      chk("d4/lat", 64'(latA), 64'd5);
      chk("d1/lat", 64'(latB), 64'd17);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 4..32.
REQ-002 Parameter DIGIT, default 2: bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT; otherwise elaboration SHALL fail.
REQ-003 iClk  input  1  clock; all state changes on rising edge.
REQ-004 iReset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 iStart  input  1  request pulse; operands and mode sampled when accepted.
REQ-006 iSA  input  1  mode: 0 = A+B, 1 = A-B.
REQ-007 iData_a  input  WIDTH  operand A, two's complement.
REQ-008 iData_b  input  WIDTH  operand B, two's complement.
REQ-009 oData  output  WIDTH+1  full-precision signed result (sign-extended A +/- B).
REQ-010 oData_C  output  1  raw carry out of the WIDTH-bit operation; for subtract, 1 = no borrow.
REQ-011 oOverflow  output  1  signed overflow of the WIDTH-bit result oData[WIDTH-1:0].
REQ-012 oBusy  output  1  high while an operation is in progress.
REQ-013 oDone  output  1  single-cycle pulse: results valid and updated.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-015 IDLE: iStart=1 SHALL latch iData_a, iData_b, iSA, clear digit counter, preload carry = iSA, go to RUN; iStart=0 stays IDLE.
REQ-016 RUN: each edge SHALL add one DIGIT-bit slice (LSB slice first) of A and (iSA ? ~B : B) with the stored carry, shift the slice into the result register, and advance the counter.
REQ-017 RUN SHALL last exactly N edges, then go to DONE; start-to-oDone latency is N+1 cycles from the accepting edge (5 for defaults).
REQ-018 DONE: oDone=1 for exactly one cycle; oData, oData_C, oOverflow SHALL update on the edge entering DONE and hold until the next entry to DONE.
REQ-019 DONE with iStart=1 SHALL accept a new operation (back-to-back, go to RUN); otherwise go to IDLE.
REQ-020 iStart while in RUN SHALL be ignored; no queueing.
REQ-021 Operand inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-022 oData[WIDTH-1:0] = WIDTH-bit sum; oData[WIDTH] = A[W-1] XOR B'[W-1] XOR carry-out, where B' is the (possibly inverted) operand.
REQ-023 oOverflow = carry into MSB XOR carry out of MSB.
REQ-024 oBusy SHALL be 1 in RUN, 0 in IDLE and DONE.

Reset
REQ-025 iReset=1 at an edge SHALL force IDLE, clear counter, carry, oData, oData_C, oOverflow, oDone, oBusy to 0, in any state.
REQ-026 Reset mid-RUN SHALL abandon the operation with no oDone pulse; iStart in the same cycle as iReset SHALL be ignored.

Structure
REQ-027 Shared package addsub_pkg SHALL hold state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and mode constants (ADD=1'b0, SUB=1'b1).
REQ-028 One sub-module digit_adder (combinational, DIGIT-bit ripple slice with carry-in, carry-out, and carry-into-MSB outputs) SHALL be instantiated once.
REQ-029 Unreachable state code 2'd3 SHALL return to IDLE.

Verification (WIDTH=8, DIGIT=2)
REQ-030 Add 0x04+0x06 -> oData=0x00A, oData_C=0, oOverflow=0, oDone 5 cycles after start.
REQ-031 Add 0x7F+0xFF -> oData=0x07E, oData_C=1, oOverflow=0; add 0x7F+0x01 -> oData=0x080, oOverflow=1.
REQ-032 Sub 0x41-0x42 -> oData=0x1FF, oData_C=0, oOverflow=0; sub 0x80-0x01 -> oData=0x17F, oData_C=1, oOverflow=1.
REQ-033 Back-to-back: iStart held high through DONE -> second oDone exactly 5 cycles after first; iStart pulses during RUN ignored.
REQ-034 iReset asserted on RUN cycle 2 -> outputs 0, no oDone, next iStart completes normally.
REQ-035 Regression with WIDTH=16, DIGIT=4 and DIGIT=1: random operands vs reference model, latency N+1 checked every operation.
